// File: rtl/brq_mem_arbiter.sv
// Shares one memory-side req/gnt/rvalid port between the instruction-fetch and LSU ports.
// Round-robin arbitration with grant locking; an in-order source FIFO routes responses back.
module brq_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            instr_req_i,
  output logic            instr_gnt_o,
  input  logic [AW-1:0]   instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [DW-1:0]   instr_rdata_o,
  output logic            instr_err_o,

  input  logic            data_req_i,
  output logic            data_gnt_o,
  input  logic            data_we_i,
  input  logic [DW/8-1:0] data_be_i,
  input  logic [AW-1:0]   data_addr_i,
  input  logic [DW-1:0]   data_wdata_i,
  output logic            data_rvalid_o,
  output logic [DW-1:0]   data_rdata_o,
  output logic            data_err_o,

  output logic            m_req_o,
  input  logic            m_gnt_i,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_be_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  input  logic            m_rvalid_i,
  input  logic [DW-1:0]   m_rdata_i,
  input  logic            m_err_i,

  output logic            unexp_rsp_o
);

  localparam int unsigned BEW = DW / 8;
  localparam int unsigned CW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  logic                      lock_q, lock_d;
  logic                      lock_src_q, lock_src_d;
  logic                      last_q, last_d;
  logic                      unexp_q, unexp_d;
  logic [MaxOutstanding-1:0] src_fifo_q, src_fifo_d;
  logic [PW-1:0]             wptr_q, wptr_d;
  logic [PW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic full, empty, sel, sel_req, xfer, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  // Source selection: a locked source wins, otherwise round-robin on a tie.
  always_comb begin
    full  = (cnt_q == CW'(MaxOutstanding));
    empty = (cnt_q == '0);
    if (lock_q) begin
      sel = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel = ~last_q;
    end else if (data_req_i) begin
      sel = SRC_DATA;
    end else begin
      sel = SRC_INSTR;
    end
    sel_req = (sel == SRC_DATA) ? data_req_i : instr_req_i;
    xfer    = m_req_o & m_gnt_i;
    pop     = m_rvalid_i & ~empty;
    head    = src_fifo_q[rptr_q];
  end

  // A full FIFO masks both requesters, even when a pop lands in the same cycle.
  assign m_req_o   = sel_req & ~full;
  assign m_addr_o  = (sel == SRC_DATA) ? data_addr_i  : instr_addr_i;
  assign m_we_o    = (sel == SRC_DATA) ? data_we_i    : 1'b0;
  assign m_be_o    = (sel == SRC_DATA) ? data_be_i    : {BEW{1'b1}};
  assign m_wdata_o = (sel == SRC_DATA) ? data_wdata_i : '0;

  assign instr_gnt_o = m_req_o & m_gnt_i & (sel == SRC_INSTR);
  assign data_gnt_o  = m_req_o & m_gnt_i & (sel == SRC_DATA);

  // Responses follow the head of the source FIFO; rdata is broadcast.
  assign instr_rvalid_o = pop & (head == SRC_INSTR);
  assign data_rvalid_o  = pop & (head == SRC_DATA);
  assign instr_err_o    = instr_rvalid_o & m_err_i;
  assign data_err_o     = data_rvalid_o & m_err_i;
  assign instr_rdata_o  = m_rdata_i;
  assign data_rdata_o   = m_rdata_i;
  assign unexp_rsp_o    = unexp_q;

  // Next-state: FIFO bookkeeping, lock tracking and round-robin history.
  always_comb begin
    src_fifo_d = src_fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    last_d     = last_q;
    if (xfer) begin
      src_fifo_d[wptr_q] = sel;
      wptr_d             = ptr_inc(wptr_q);
      last_d             = sel;
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    cnt_d      = cnt_q + CW'(xfer) - CW'(pop);
    lock_d     = m_req_o & ~m_gnt_i;
    lock_src_d = lock_d ? sel : lock_src_q;
    unexp_d    = unexp_q | (m_rvalid_i & empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_fifo_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
      last_q     <= SRC_DATA;
      unexp_q    <= 1'b0;
    end else begin
      src_fifo_q <= src_fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      last_q     <= last_d;
      unexp_q    <= unexp_d;
    end
  end

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Directed plus randomized bench for brq_mem_arbiter against a queue-based reference model.
module tb_brq_mem_arbiter;

  localparam int unsigned MAXO = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            instr_req = 1'b0;
  logic [AW-1:0]   instr_addr = '0;
  logic            data_req = 1'b0;
  logic            data_we = 1'b0;
  logic [DW/8-1:0] data_be = '0;
  logic [AW-1:0]   data_addr = '0;
  logic [DW-1:0]   data_wdata = '0;
  logic            m_gnt = 1'b0;
  logic            m_rvalid = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_err = 1'b0;

  logic            instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [DW-1:0]   instr_rdata_o;
  logic            data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0]   data_rdata_o;
  logic            m_req_o, m_we_o, unexp_rsp_o;
  logic [DW/8-1:0] m_be_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;

  brq_mem_arbiter #(.MaxOutstanding(MAXO), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req), .data_gnt_o(data_gnt_o), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid),
    .m_rdata_i(m_rdata), .m_err_i(m_err), .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding sources in issue order (0=instr, 1=data).
  int q[$];
  int last_src;
  bit held;
  int held_src;
  bit unexp_m;

  task automatic model_reset();
    q.delete();
    last_src = 1;
    held     = 0;
    held_src = 0;
    unexp_m  = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Check every output against the model for the current inputs, then advance one clock.
  task automatic cycle();
    int  sel;
    bit  full, mreq, irv, drv;
    #3;
    full = (q.size() == MAXO);
    if (held) sel = held_src;
    else if (instr_req && data_req) sel = 1 - last_src;
    else if (data_req) sel = 1;
    else sel = 0;
    mreq = !full && ((sel == 1) ? data_req : instr_req);
    irv  = m_rvalid && q.size() > 0 && q[0] == 0;
    drv  = m_rvalid && q.size() > 0 && q[0] == 1;
    chk("m_req", 64'(m_req_o), 64'(mreq));
    chk("instr_gnt", 64'(instr_gnt_o), 64'(mreq && m_gnt && sel == 0));
    chk("data_gnt", 64'(data_gnt_o), 64'(mreq && m_gnt && sel == 1));
    if (mreq) begin
      chk("m_addr", 64'(m_addr_o), 64'((sel == 1) ? data_addr : instr_addr));
      chk("m_we", 64'(m_we_o), 64'((sel == 1) ? data_we : 1'b0));
      chk("m_be", 64'(m_be_o), 64'((sel == 1) ? data_be : 4'hF));
      chk("m_wdata", 64'(m_wdata_o), 64'((sel == 1) ? data_wdata : 32'h0));
    end
    chk("instr_rvalid", 64'(instr_rvalid_o), 64'(irv));
    chk("data_rvalid", 64'(data_rvalid_o), 64'(drv));
    chk("instr_err", 64'(instr_err_o), 64'(irv && m_err));
    chk("data_err", 64'(data_err_o), 64'(drv && m_err));
    chk("instr_rdata", 64'(instr_rdata_o), 64'(m_rdata));
    chk("data_rdata", 64'(data_rdata_o), 64'(m_rdata));
    chk("unexp", 64'(unexp_rsp_o), 64'(unexp_m));
    if (m_rvalid && q.size() == 0) unexp_m = 1;
    if (m_rvalid && q.size() > 0) void'(q.pop_front());
    if (mreq && m_gnt) begin
      q.push_back(sel);
      last_src = sel;
      held     = 0;
    end else if (mreq) begin
      held     = 1;
      held_src = sel;
    end else begin
      held = 0;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; m_gnt = 0; m_rvalid = 0; m_err = 0;
  endtask

  initial begin
    int exp_rr[4];
    model_reset();
    // Reset state
    @(posedge clk_i); #1;
    chk("rst_m_req", 64'(m_req_o), 64'(0));
    chk("rst_gnts", 64'({instr_gnt_o, data_gnt_o}), 64'(0));
    chk("rst_rvalids", 64'({instr_rvalid_o, data_rvalid_o}), 64'(0));
    chk("rst_unexp", 64'(unexp_rsp_o), 64'(0));
    rst_i = 0;

    // Single fetch and its response
    instr_req = 1; instr_addr = 32'h100; m_gnt = 1;
    #2;
    chk("fetch_addr", 64'(m_addr_o), 64'h100);
    chk("fetch_we", 64'(m_we_o), 64'(0));
    chk("fetch_be", 64'(m_be_o), 64'hF);
    chk("fetch_gnt", 64'(instr_gnt_o), 64'(1));
    cycle();
    instr_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    #2;
    chk("fetch_rvalid", 64'(instr_rvalid_o), 64'(1));
    chk("fetch_data_rvalid", 64'(data_rvalid_o), 64'(0));
    chk("fetch_rdata", 64'(instr_rdata_o), 64'hDEADBEEF);
    cycle();

    // Round-robin: instr was granted last, so data leads
    exp_rr = '{1, 0, 1, 0};
    instr_req = 1; data_req = 1; m_gnt = 1; m_rvalid = 0;
    instr_addr = 32'h1000; data_addr = 32'h2000; data_we = 1; data_be = 4'h3; data_wdata = 32'h55AA;
    for (int k = 0; k < 4; k++) begin
      m_rvalid = (k > 0); m_rdata = 32'h100 + 32'(k);
      #2;
      chk("rr_data_gnt", 64'(data_gnt_o), 64'(exp_rr[k] == 1));
      chk("rr_instr_gnt", 64'(instr_gnt_o), 64'(exp_rr[k] == 0));
      cycle();
    end
    instr_req = 0; data_req = 0; m_gnt = 0; m_rvalid = 1;
    #2;
    chk("rr_last_rsp_instr", 64'(instr_rvalid_o), 64'(1));
    cycle();

    // Lock: data held at 0x200 without grant while instr joins
    m_rvalid = 0; data_req = 1; data_addr = 32'h200; data_we = 0; data_be = 4'hC;
    #2; chk("lock_addr0", 64'(m_addr_o), 64'h200); cycle();
    instr_req = 1; instr_addr = 32'h300;
    #2; chk("lock_addr1", 64'(m_addr_o), 64'h200); chk("lock_igt1", 64'(instr_gnt_o), 64'(0)); cycle();
    #2; chk("lock_addr2", 64'(m_addr_o), 64'h200); cycle();
    m_gnt = 1;
    #2; chk("lock_dgnt", 64'(data_gnt_o), 64'(1)); chk("lock_addr3", 64'(m_addr_o), 64'h200); cycle();
    data_addr = 32'h204;
    #2; chk("lock_igt", 64'(instr_gnt_o), 64'(1)); chk("lock_iaddr", 64'(m_addr_o), 64'h300); cycle();

    // Full: two outstanding block everything, even with a same-cycle pop
    #2; chk("full_mreq", 64'(m_req_o), 64'(0)); chk("full_gnts", 64'({instr_gnt_o, data_gnt_o}), 64'(0)); cycle();
    m_rvalid = 1; m_rdata = 32'h77;
    #2; chk("full_pop_mreq", 64'(m_req_o), 64'(0)); chk("full_pop_drv", 64'(data_rvalid_o), 64'(1)); cycle();
    m_rvalid = 0;
    #2; chk("full_after_mreq", 64'(m_req_o), 64'(1)); chk("full_after_dgnt", 64'(data_gnt_o), 64'(1)); cycle();

    // Error routed to the data port
    idle_inputs(); m_rvalid = 1;
    #2; chk("err_instr_rv", 64'(instr_rvalid_o), 64'(1)); cycle();
    m_err = 1;
    #2; chk("err_data_rv", 64'(data_rvalid_o), 64'(1)); chk("err_data_err", 64'(data_err_o), 64'(1)); cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      instr_req  = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      instr_addr = $urandom;
      data_addr  = $urandom;
      data_we    = 1'($urandom);
      data_be    = 4'($urandom);
      data_wdata = $urandom;
      m_gnt      = ($urandom_range(0, 9) < 6);
      m_rvalid   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata    = $urandom;
      m_err      = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle_inputs();
    for (int n = 0; n < 8 && q.size() > 0; n++) begin
      m_rvalid = 1; m_rdata = $urandom;
      cycle();
    end
    chk("drain_empty", 64'(q.size()), 64'(0));

    // Unexpected response with nothing outstanding
    idle_inputs(); m_rvalid = 1;
    #2; chk("unexp_no_rv", 64'({instr_rvalid_o, data_rvalid_o}), 64'(0)); cycle();
    m_rvalid = 0;
    #2; chk("unexp_set", 64'(unexp_rsp_o), 64'(1)); cycle();
    cycle();

    // Reset mid-flight
    instr_req = 1; instr_addr = 32'h40; m_gnt = 1;
    cycle();
    idle_inputs();
    #1 rst_i = 1;
    #1;
    chk("rstmid_m_req", 64'(m_req_o), 64'(0));
    chk("rstmid_gnts", 64'({instr_gnt_o, data_gnt_o}), 64'(0));
    chk("rstmid_rvalids", 64'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 64'(0));
    chk("rstmid_unexp", 64'(unexp_rsp_o), 64'(0));
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 0;
    m_rvalid = 1; m_rdata = 32'hCAFE;
    #2; chk("late_rsp_no_rv", 64'(instr_rvalid_o), 64'(0)); cycle();
    m_rvalid = 0;
    #2; chk("late_rsp_unexp", 64'(unexp_rsp_o), 64'(1)); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
